// File: rtl/aes_sbox_pkg.sv
// Shared AES S-box tables and lookup helpers for the SubBytes/InvSubBytes engine.
package aes_sbox_pkg;

    localparam int unsigned LANES_MAX = 16;
    localparam int unsigned PIPE_MAX  = 4;

    // Row r of each table holds the substitutions for bytes 0xr0..0xrF, left to right.
    localparam logic [0:255][7:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        return SBOX_FWD[b];
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        return SBOX_INV[b];
    endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// Single-byte S-box lookup; forward table only present with AES_SBOX_FWD_EN defined.
module aes_sbox_lane
    import aes_sbox_pkg::*;
(
    input  logic       inv,
    input  logic [7:0] din,
    output logic [7:0] dout
);

`ifdef AES_SBOX_FWD_EN
    always_comb dout = inv ? sbox_inv(din) : sbox_fwd(din);
`else
    logic unused_inv;
    assign unused_inv = inv;
    always_comb dout = sbox_inv(din);
`endif

endmodule

// File: rtl/aes_sbox_pipe.sv
// Multi-lane pipelined AES S-box with valid/ready back-pressure.
// Define AES_SBOX_FWD_EN to add the forward table; otherwise every beat uses the inverse table.
module aes_sbox_pipe
    import aes_sbox_pkg::*;
#(
    parameter int unsigned LANES = 16,
    parameter int unsigned PIPE  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic               out_inv,
    output logic               busy
);

    if (LANES < 1 || LANES > LANES_MAX || PIPE < 1 || PIPE > PIPE_MAX) begin : g_bad_param
        $error("aes_sbox_pipe: LANES must be 1..16 and PIPE 1..4");
    end

    logic [8*LANES-1:0] sub;
    logic [PIPE-1:0]    v;
    logic [PIPE-1:0]    t;
    logic [8*LANES-1:0] d [PIPE];
    logic [PIPE-1:0]    ld;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        aes_sbox_lane u_lane (
            .inv  (in_inv),
            .din  (in_data[8*i +: 8]),
            .dout (sub[8*i +: 8])
        );
    end

    // Closed form of the ready chain: a stage loads if it or any later stage is empty, or the sink takes.
    always_comb begin
        ld = '0;
        for (int unsigned k = 0; k < PIPE; k++) begin
            ld[k] = out_ready;
            for (int unsigned j = k; j < PIPE; j++) begin
                if (!v[j]) ld[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
        end else begin
            if (ld[0]) v[0] <= in_valid;
            for (int unsigned k = 1; k < PIPE; k++) begin
                if (ld[k]) v[k] <= v[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ld[0]) begin
            d[0] <= sub;
            t[0] <= in_inv;
        end
        for (int unsigned k = 1; k < PIPE; k++) begin
            if (ld[k]) begin
                d[k] <= d[k-1];
                t[k] <= t[k-1];
            end
        end
    end

    assign in_ready  = rst || ld[0];
    assign out_valid = v[PIPE-1];
    assign out_data  = d[PIPE-1];
    assign out_inv   = t[PIPE-1];
    assign busy      = |v;

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Bench for aes_sbox_pipe: three configurations share stimulus, each scored against a GF(2^8) model.
module tb_aes_sbox_pipe;

    localparam int unsigned NCFG = 3;
    localparam int unsigned CFG_L [NCFG] = '{16, 4, 4};
    localparam int unsigned CFG_P [NCFG] = '{2, 1, 4};

    typedef struct {
        logic [127:0] data;
        logic         inv;
        int unsigned  acc;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_data;
    logic         in_inv;
    logic         out_ready;

    int unsigned  cyc = 0;
    int           n_cmp = 0;
    int           n_bad = 0;

    logic [7:0]   ref_fwd [256];
    logic [7:0]   ref_inv [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box = multiplicative inverse in GF(2^8) followed by the AES affine map.
    task automatic build_ref();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] b = '0;
            logic [7:0] s;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
            ref_fwd[x] = s;
            ref_inv[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] din, input logic inv, input int unsigned lanes);
        logic [127:0] r = '0;
        for (int unsigned i = 0; i < lanes; i++) begin
`ifdef AES_SBOX_FWD_EN
            r[8*i +: 8] = inv ? ref_inv[din[8*i +: 8]] : ref_fwd[din[8*i +: 8]];
`else
            r[8*i +: 8] = ref_inv[din[8*i +: 8]];
`endif
        end
        return r;
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int unsigned L = CFG_L[g];
        localparam int unsigned P = CFG_P[g];

        logic [8*L-1:0] od;
        logic           ov, oi, ir, bz;
        logic           exp_ov, exp_rdy;
        beat_t          q [$];

        aes_sbox_pipe #(.LANES(L), .PIPE(P)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (ir),
            .in_data   (in_data[8*L-1:0]),
            .in_inv    (in_inv),
            .out_valid (ov),
            .out_ready (out_ready),
            .out_data  (od),
            .out_inv   (oi),
            .busy      (bz)
        );

        // Oldest beat has nothing ahead of it, so it reaches the output P-1 edges after accept.
        always @(negedge clk) begin
            if (cyc > 0) begin
                exp_ov  = (q.size() > 0) && (cyc >= q[0].acc + P - 1);
                exp_rdy = rst || (q.size() < int'(P)) || out_ready;
                check($sformatf("cfg%0d.out_valid", g), 128'(ov), 128'(exp_ov));
                check($sformatf("cfg%0d.busy", g), 128'(bz), 128'(q.size() != 0));
                check($sformatf("cfg%0d.in_ready", g), 128'(ir), 128'(exp_rdy));
                if (exp_ov) begin
                    check($sformatf("cfg%0d.out_data", g), 128'(od), q[0].data);
                    check($sformatf("cfg%0d.out_inv", g), 128'(oi), 128'(q[0].inv));
                end
                if (rst) begin
                    q.delete();
                end else begin
                    if (exp_ov && out_ready) void'(q.pop_front());
                    if (in_valid && exp_rdy)
                        q.push_back('{data: ref_sub(in_data, in_inv, L), inv: in_inv, acc: cyc + 1});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] orig   [16];
    logic [127:0] fwdres [16];
    logic [7:0]   e;

    initial begin
        build_ref();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b1;
        repeat (2) step();
        check("rst.out_valid", 128'(g_dut[0].ov), 128'(0));
        check("rst.busy", 128'(g_dut[0].bz), 128'(0));
        rst = 1'b0;
        step();

        in_valid = 1'b1; in_inv = 1'b1;
        in_data = {{12{8'h52}}, 8'h7c, 8'hff, 8'h00, 8'h63};
        step();
        in_valid = 1'b0;
        check("inv.early_valid", 128'(g_dut[0].ov), 128'(0));
        step();
        check("inv.valid", 128'(g_dut[0].ov), 128'(1));
        check("inv.data", g_dut[0].od, {{12{8'h48}}, 8'h01, 8'h7d, 8'h52, 8'h00});
        check("inv.tag", 128'(g_dut[0].oi), 128'(1));

`ifdef AES_SBOX_FWD_EN
        in_valid = 1'b1; in_inv = 1'b0;
        in_data = {96'h0, 8'hff, 8'h01, 8'h53, 8'h00};
        step();
        in_valid = 1'b0;
        step();
        check("fwd.data", 128'(g_dut[0].od[31:0]), 128'(32'h167ced63));
`endif

        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_inv = i[0]; in_data = '0;
            step();
            check("alt.in_ready", 128'(g_dut[0].ir), 128'(1));
            if (i > 0) begin
                e = 8'h52;
`ifdef AES_SBOX_FWD_EN
                if (!((i - 1) & 1)) e = 8'h63;
`endif
                check("alt.valid", 128'(g_dut[0].ov), 128'(1));
                check("alt.data", 128'(g_dut[0].od[7:0]), 128'(e));
                check("alt.tag", 128'(g_dut[0].oi), 128'((i - 1) & 1));
            end
        end
        in_valid = 1'b0;
        repeat (3) step();

`ifdef AES_SBOX_FWD_EN
        for (int b = 0; b < 16; b++)
            for (int l = 0; l < 16; l++) orig[b][8*l +: 8] = 8'(b * 16 + l);
        in_inv = 1'b0;
        for (int b = 0; b < 16; b++) begin
            in_data = orig[b]; in_valid = 1'b1;
            step();
            if (b > 0) fwdres[b-1] = g_dut[0].od;
        end
        in_valid = 1'b0;
        step();
        fwdres[15] = g_dut[0].od;
        in_inv = 1'b1;
        for (int b = 0; b < 16; b++) begin
            in_data = fwdres[b]; in_valid = 1'b1;
            step();
            if (b > 0) check("roundtrip", g_dut[0].od, orig[b-1]);
        end
        in_valid = 1'b0;
        step();
        check("roundtrip", g_dut[0].od, orig[15]);
        repeat (3) step();
`endif

        for (int c = 0; c < 300; c++) begin
            if (c == 150) begin
                in_valid = 1'b0; out_ready = 1'b1;
                repeat (6) step();
                out_ready = 1'b0; in_valid = 1'b1;
                repeat (2) step();
                rst = 1'b1;
                step();
                rst = 1'b0; in_valid = 1'b0;
                check("mid_rst.cfg0.valid", 128'(g_dut[0].ov), 128'(0));
                check("mid_rst.cfg0.busy", 128'(g_dut[0].bz), 128'(0));
                check("mid_rst.cfg1.valid", 128'(g_dut[1].ov), 128'(0));
                check("mid_rst.cfg1.busy", 128'(g_dut[1].bz), 128'(0));
                check("mid_rst.cfg2.valid", 128'(g_dut[2].ov), 128'(0));
                check("mid_rst.cfg2.busy", 128'(g_dut[2].bz), 128'(0));
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inv    = 1'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = 1'($urandom_range(0, 1));
            step();
        end

        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_sbox_pipe.md
# aes_sbox_pipe

Multi-lane, pipelined AES byte-substitution unit: applies the FIPS-197 S-box (forward) or inverse S-box to LANES bytes per beat. Carries a per-beat mode tag and uses a valid/ready handshake with full back-pressure. Serves as the shared SubBytes/InvSubBytes engine for the encrypt and decrypt round datapaths and the key-expansion SubWord path, where LANES=4.

## Interface
- LANES, 16: number of byte lanes per beat, 1..16.
- PIPE, 2: register stages from accept to output, 1..4.
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  unit accepts the beat this cycle.
- in_data  in  8*LANES  lane i = bits [8i+7:8i].
- in_inv  in  1  1 = inverse S-box, 0 = forward S-box.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts the output beat.
- out_data  out  8*LANES  substituted bytes, same lane order.
- out_inv  out  1  mode tag travelling with the beat.
- busy  out  1  any stage holds a valid beat.

## Operation
- Transfer on the input side: in_valid && in_ready. Transfer on the output side: out_valid && out_ready.
- Lookup is combinational on in_data, per lane, selected by in_inv. The result and in_inv are captured into stage 1 on the input transfer.
- Stages 2..PIPE are plain delay registers, each holding a valid bit, data and tag.
- Stage k loads from stage k-1 when its own valid bit is 0, or when stage k+1 loads this cycle. For the last stage, "stage k+1 loads" means out_ready.
- in_ready = !v1 || (stage 2 loads). For PIPE=1: in_ready = !v1 || out_ready. The ready path is combinational through the chain.
- A stage that does not load holds its data and tag unchanged. Its valid bit clears only when it is unloaded and nothing replaces it.
- No bubbles: with out_ready held at 1, one beat is accepted every cycle.
- Data and tag registers are not reset. Only valid bits are reset.
- out_data/out_inv are don't-care while out_valid=0.
- busy = OR of all stage valid bits.
- Illegal parameters (LANES=0 or >16, PIPE=0 or >4) are caught by an elaboration-time check.

## Timing
- Reset values: out_valid=0, busy=0, and all stage valid bits =0.
- While rst=1, in_ready reads 1 but nothing is captured.
- Reset asserted mid-operation discards all in-flight beats on the next edge. No output transfer happens in that cycle's aftermath.
- Latency: a beat accepted at edge N has out_valid=1 after edge N+PIPE-1, i.e. it is visible in the cycle following edge N+PIPE-1. PIPE=1 means out_valid in the cycle after accept.
- Full pipe with out_ready=0: all PIPE stages valid, in_ready=0. Capacity is PIPE beats.
- Simultaneous output transfer and input transfer with a full pipe: both occur, and occupancy stays at PIPE.
- The mode may change on every beat. Each output uses the in_inv it was accepted with.

## Configuration
- AES_SBOX_FWD_EN defined: the forward table is compiled in, and in_inv selects the table per beat.
- AES_SBOX_FWD_EN undefined: inverse only. in_inv is still registered and reported on out_inv, but the inverse table is always used and no forward table logic is generated.

## Structure
- Package aes_sbox_pkg holds:
  - the 256-entry forward and inverse tables as constant arrays;
  - the lookup functions sbox_fwd(byte) and sbox_inv(byte);
  - LANES_MAX=16 and PIPE_MAX=4.
- Sub-module aes_sbox_lane: one combinational byte lookup with a mode input, instantiated LANES times by generate.
- The pipeline registers and handshake logic live in the top.

## Test plan
- Inverse, LANES=16, PIPE=2, out_ready=1: lane bytes 0x63, 0x00, 0xff, 0x7c, rest 0x52 -> out 0x00, 0x52, 0x7d, 0x01, rest 0x48, with out_valid two cycles after accept.
- Forward (FWD_EN defined): 0x00, 0x53, 0x01, 0xff -> 0x63, 0xed, 0x7c, 0x16.
- Round trip: all 256 values fed forward and the results fed inverse return the original bytes.
- Back-pressure: stream 10 beats with a random out_ready pattern. Require an in-order, lossless output sequence and in_ready=0 exactly when PIPE beats are held. Check that data stays stable while out_valid && !out_ready.
- Alternating in_inv every beat with input 0x00: outputs alternate 0x63/0x52 and out_inv matches each beat's tag. Without FWD_EN, all outputs are 0x52.
- Reset asserted with 2 beats in flight: the next cycle shows out_valid=0 and busy=0, and no stale beat appears afterwards. Run for PIPE=1 and PIPE=4, and for LANES=4.
